wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs (IR, PC+8, ALU result, memory read data, destination register).
- Forms the final write-back value, including load sub-word extraction and sign/zero extension, and commits it to a 32x32 register file.
- Serves the ID stage through two read ports with same-cycle write-through bypass, plus a commit counter for debug.

Parameters:
- NREG, 32, number of architectural registers (index width 5 bits; fixed).
- CNT_W, 16, width of the commit counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-high.
- IR_In  input  32  instruction in W stage.
- PC8_In  input  32  PC+8 of that instruction (link value).
- AO_In  input  32  ALU result / effective address.
- DR_In  input  32  raw word read from data memory.
- RegWrite_In  input  5  destination register number; 0 means no write.
- RA1  input  5  read address, port 1.
- RA2  input  5  read address, port 2.
- RD1  output  32  read data, port 1 (combinational).
- RD2  output  32  read data, port 2 (combinational).
- WD_Out  output  32  write-back value formed this cycle (combinational).
- WE_Out  output  1  high when a commit happens at the next edge.
- WriteCount  output  CNT_W  registered count of committed writes.

Behaviour:
- Reset is synchronous and active-high: on a rising clk with reset=1, all 32 registers clear to 0 and WriteCount clears to 0.
- Reset has priority over a simultaneous write; that write is dropped.
- Write-back source, decoded from IR_In[31:26] (op) and IR_In[5:0] (funct):
  - op 000011 (jal), or op 000000 with funct 001001 (jalr): PC8_In.
  - lw 100011: DR_In.
  - lb 100000 / lbu 100100: byte selected by AO_In[1:0] (00 -> DR[7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24]). lb sign-extends, lbu zero-extends.
  - lh 100001 / lhu 100101: halfword selected by AO_In[1] (0 -> DR[15:0], 1 -> DR[31:16]); AO_In[0] is ignored. lh sign-extends, lhu zero-extends.
  - All other opcodes: AO_In.
- WE_Out = (RegWrite_In != 0) and not reset.
- Commit: at a rising edge with WE_Out=1, reg[RegWrite_In] <= WD_Out. Register 0 is never written and always reads 0.
- Latency: a write issued in cycle N is visible in the array from cycle N+1.
- Read-port bypass, applied per port:
  - RAx == 0 -> RDx = 0.
  - Else if WE_Out and RAx == RegWrite_In -> RDx = WD_Out.
  - Else RDx = reg[RAx].
  - Both ports may hit the bypass in the same cycle.
- WriteCount increments by 1 on each commit and saturates at all-ones (no wrap).
- WD_Out is always driven, even when WE_Out=0.
- No stall or flush inputs: a bubble arrives as RegWrite_In=0 and is ignored.

Test Plan:
- Reset: write reg 5 = 0x1234, assert reset one cycle -> RD1(RA1=5)=0, WriteCount=0. A write presented during the reset cycle does not commit.
- ALU write and bypass: IR=addu, AO=0xDEADBEEF, RegWrite=8, RA1=RA2=8 -> RD1=RD2=0xDEADBEEF in the same cycle. After the edge with RegWrite=0, RD1 still reads 0xDEADBEEF.
- Loads with DR=0x80FF7F01:
  - lb: AO[1:0]=00 -> 0x00000001; 01 -> 0x0000007F; 10 -> 0xFFFFFFFF; 11 -> 0xFFFFFF80.
  - lbu, AO[1:0]=11 -> 0x00000080.
  - lh, AO[1]=1 -> 0xFFFF80FF.
  - lhu, AO[1]=0 -> 0x00007F01.
- Link: jal with PC8=0x00003010, RegWrite=31 -> reg31=0x00003010. jalr with RegWrite=4 -> reg4=PC8.
- Register 0: RegWrite=0, AO=0xFFFFFFFF -> WE_Out=0, RD1(RA1=0)=0, WriteCount unchanged.
- Counter saturation: with CNT_W=4, issue 20 commits -> WriteCount reaches 0xF and holds.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back bundle, ID-stage read ports and debug commit count.
interface wb_regfile_if #(parameter int CNT_W = 16);
    logic [31:0]      ir;
    logic [31:0]      pc8;
    logic [31:0]      ao;
    logic [31:0]      dr;
    logic [4:0]       reg_write;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic [31:0]      wd;
    logic             we;
    logic [CNT_W-1:0] write_count;
    modport master (
        output ir, pc8, ao, dr, reg_write, ra1, ra2,
        input  rd1, rd2, wd, we, write_count
    );
    modport slave (
        input  ir, pc8, ao, dr, reg_write, ra1, ra2,
        output rd1, rd2, wd, we, write_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back value formation (loads, links, ALU) and 32x32 register file
// with write-through read bypass and a saturating commit counter.
module wb_regfile #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    logic [31:0]      rf [NREG];
    logic [CNT_W-1:0] cnt;
    logic [5:0]       op;
    logic [7:0]       b;
    logic [15:0]      h;
    logic             link;
    always_comb begin
        op   = bus.ir[31:26];
        link = op == 6'h03 || (op == 6'h00 && bus.ir[5:0] == 6'h09);
        b    = bus.dr[{bus.ao[1:0], 3'b000} +: 8];
        h    = bus.ao[1] ? bus.dr[31:16] : bus.dr[15:0];
        bus.wd = link         ? bus.pc8 :
                 op == 6'h23  ? bus.dr :
                 op == 6'h20  ? {{24{b[7]}}, b} :
                 op == 6'h24  ? {24'h0, b} :
                 op == 6'h21  ? {{16{h[15]}}, h} :
                 op == 6'h25  ? {16'h0, h} :
                 bus.ao;
    end
    assign bus.we  = bus.reg_write != 5'd0 && !reset;
    // Same-cycle write-through lets ID see a value committing at this edge.
    assign bus.rd1 = bus.ra1 == 5'd0 ? 32'h0 :
                     (bus.we && bus.ra1 == bus.reg_write) ? bus.wd : rf[bus.ra1];
    assign bus.rd2 = bus.ra2 == 5'd0 ? 32'h0 :
                     (bus.we && bus.ra2 == bus.reg_write) ? bus.wd : rf[bus.ra2];
    assign bus.write_count = cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= 32'h0;
            cnt <= '0;
        end else if (bus.we) begin
            rf[bus.reg_write] <= bus.wd;
            cnt <= &cnt ? cnt : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; a 4-bit-counter twin checks saturation.
module tb_wb_regfile;
    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cnt_model = 0;
    exp_t sb[$];

    localparam logic [5:0] OP_RT = 6'h00, OP_JAL = 6'h03, OP_LW = 6'h23, OP_LB = 6'h20,
                           OP_LBU = 6'h24, OP_LH = 6'h21, OP_LHU = 6'h25;

    wb_regfile_if #(.CNT_W(16)) bus ();
    wb_regfile_if #(.CNT_W(4))  bus4 ();

    assign bus4.ir = bus.ir;
    assign bus4.pc8 = bus.pc8;
    assign bus4.ao = bus.ao;
    assign bus4.dr = bus.dr;
    assign bus4.reg_write = bus.reg_write;
    assign bus4.ra1 = bus.ra1;
    assign bus4.ra2 = bus.ra2;

    wb_regfile #(.NREG(32), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    wb_regfile #(.NREG(32), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return bus.rd1;
            1: return bus.rd2;
            2: return bus.wd;
            3: return {31'h0, bus.we};
            4: return {16'h0, bus.write_count};
            default: return {28'h0, bus4.write_count};
        endcase
    endfunction

    task automatic drain();
        #2;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        if (reset) cnt_model = 0;
        else if (bus.reg_write != 5'd0) cnt_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ao,
                         input logic [4:0] rw);
        bus.ir = {op, 20'h0, fn};
        bus.ao = ao;
        bus.reg_write = rw;
    endtask

    function automatic logic [31:0] sat4(input int c);
        return c > 15 ? 32'd15 : 32'(c);
    endfunction

    logic [5:0]  ld_op [7] = '{OP_LB, OP_LB, OP_LB, OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [31:0] ld_ao [7] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] ld_ex [7] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                               32'h00000080, 32'hFFFF80FF, 32'h00007F01};

    initial begin
        bus.pc8 = 0; bus.dr = 0; bus.ra1 = 0; bus.ra2 = 0;
        drive(OP_RT, 6'h21, 0, 0);
        tick(); tick();
        reset = 0;
        bus.ra1 = 5;
        expect_val(0, "reset_rd1", 0);
        expect_val(4, "reset_cnt", 0);
        drain();
        drive(OP_RT, 6'h21, 32'h1234, 5);
        tick();
        drive(OP_RT, 6'h21, 0, 0);
        expect_val(0, "w5_rd1", 32'h1234);
        expect_val(4, "w5_cnt", 1);
        drain();
        reset = 1;
        drive(OP_RT, 6'h21, 32'h55, 6);
        bus.ra2 = 6;
        expect_val(3, "we_in_reset", 0);
        drain();
        tick();
        reset = 0;
        drive(OP_RT, 6'h21, 0, 0);
        expect_val(0, "post_rst_r5", 0);
        expect_val(1, "post_rst_r6", 0);
        expect_val(4, "post_rst_cnt", 0);
        drain();
        drive(OP_RT, 6'h21, 32'hDEADBEEF, 8);
        bus.ra1 = 8; bus.ra2 = 8;
        expect_val(3, "alu_we", 1);
        expect_val(0, "byp_rd1", 32'hDEADBEEF);
        expect_val(1, "byp_rd2", 32'hDEADBEEF);
        drain();
        tick();
        drive(OP_RT, 6'h21, 0, 0);
        expect_val(0, "alu_held", 32'hDEADBEEF);
        drain();
        bus.dr = 32'h80FF7F01;
        bus.ra1 = 9;
        for (int i = 0; i < 7; i++) begin
            drive(ld_op[i], 6'h00, ld_ao[i], 9);
            expect_val(2, $sformatf("load%0d_wd", i), ld_ex[i]);
            expect_val(0, $sformatf("load%0d_byp", i), ld_ex[i]);
            drain();
            tick();
        end
        drive(OP_RT, 6'h21, 0, 0);
        expect_val(0, "load_commit", 32'h00007F01);
        drain();
        drive(OP_JAL, 6'h00, 32'h777, 31);
        bus.pc8 = 32'h00003010;
        tick();
        drive(OP_RT, 6'h09, 32'h888, 4);
        bus.pc8 = 32'h00004444;
        tick();
        drive(OP_LW, 6'h00, 32'h200, 10);
        bus.ra1 = 31; bus.ra2 = 4;
        expect_val(0, "jal_r31", 32'h00003010);
        expect_val(1, "jalr_r4", 32'h00004444);
        expect_val(2, "lw_wd", 32'h80FF7F01);
        drain();
        tick();
        drive(OP_RT, 6'h21, 32'hFFFFFFFF, 0);
        bus.ra1 = 0;
        expect_val(3, "r0_we", 0);
        expect_val(0, "r0_rd1", 0);
        expect_val(2, "r0_wd", 32'hFFFFFFFF);
        drain();
        tick();
        bus.ra1 = 10;
        expect_val(0, "lw_commit", 32'h80FF7F01);
        expect_val(4, "r0_cnt", 32'(cnt_model));
        drain();
        for (int i = 0; i < 20; i++) begin
            drive(OP_RT, 6'h21, 32'(i), 5'(1 + i % 30));
            tick();
            if (i % 5 == 4) begin
                expect_val(5, $sformatf("cnt4_%0d", i), sat4(cnt_model));
                expect_val(4, $sformatf("cnt16_%0d", i), 32'(cnt_model));
                drain();
            end
        end
        drive(OP_RT, 6'h21, 0, 0);
        tick();
        expect_val(5, "cnt4_hold", 32'd15);
        drain();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
